// File: rtl/fpu_pkg.sv
// Shared types and constants for the FP multiplier normalise/round stage.
package fpu_pkg;

  localparam int MAN_W_DEF = 23;
  localparam int EXP_W_DEF = 8;

  typedef enum logic [1:0] {
    RNE = 2'd0,
    RTZ = 2'd1,
    RUP = 2'd2,
    RDN = 2'd3
  } rnd_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_NORM  = 2'd1,
    ST_ROUND = 2'd2,
    ST_HOLD  = 2'd3
  } norm_state_e;

  function automatic int exp_max_f(input int ew);
    return (1 << ew) - 1;
  endfunction

  localparam int EXP_MAX = exp_max_f(EXP_W_DEF);
  localparam int BIAS    = (1 << (EXP_W_DEF - 1)) - 1;

endpackage

// File: rtl/fp_normalize_round_if.sv
// Input/result handshake bundle between the multiplier array and the normaliser.
interface fp_normalize_round_if
  import fpu_pkg::*;
#(
  parameter int MAN_W = MAN_W_DEF,
  parameter int EXP_W = EXP_W_DEF
);
  localparam int PROD_W = 2 * (MAN_W + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic [PROD_W-1:0]        prod;
  logic signed [EXP_W+1:0]  exp_in;
  logic                     sign_in;
  rnd_mode_e                rnd_mode;
  logic                     out_valid;
  logic                     out_ready;
  logic [EXP_W+MAN_W:0]     res;
  logic                     overflow;
  logic                     underflow;
  logic                     inexact;

  modport master (
    output in_valid, prod, exp_in, sign_in, rnd_mode, out_ready,
    input  in_ready, out_valid, res, overflow, underflow, inexact
  );

  modport slave (
    input  in_valid, prod, exp_in, sign_in, rnd_mode, out_ready,
    output in_ready, out_valid, res, overflow, underflow, inexact
  );
endinterface

// File: rtl/lzc.sv
// Combinational leading-zero counter; count equals W when the vector is all zero.
module lzc #(
  parameter int W     = 48,
  parameter int CNT_W = $clog2(W + 1)
) (
  input  logic [W-1:0]     in_vec,
  output logic [CNT_W-1:0] cnt,
  output logic             all_zero
);

  // Later (higher) set bits override earlier ones, leaving the MSB-most hit.
  always_comb begin
    cnt = CNT_W'(W);
    for (int i = 0; i < W; i++) begin
      cnt = in_vec[i] ? CNT_W'(W - 1 - i) : cnt;
    end
    all_zero = ~|in_vec;
  end

endmodule

// File: rtl/fp_normalize_round.sv
// Sequential normalise-and-round stage: IDLE -> NORM -> ROUND -> HOLD, one op in flight.
module fp_normalize_round
  import fpu_pkg::*;
#(
  parameter int MAN_W = MAN_W_DEF,
  parameter int EXP_W = EXP_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  fp_normalize_round_if.slave bus
);
  localparam int PROD_W = 2 * (MAN_W + 1);
  localparam int XW     = EXP_W + 2;
  localparam int RES_W  = 1 + EXP_W + MAN_W;
  localparam int CNT_W  = $clog2(PROD_W + 1);
  localparam logic signed [XW-1:0] EXP_TOP = XW'(exp_max_f(EXP_W));

  norm_state_e             state_q, state_d;
  logic [PROD_W-1:0]       prod_q, prod_d;
  logic signed [XW-1:0]    exp_q, exp_d;
  logic                    sign_q, sign_d;
  rnd_mode_e               mode_q, mode_d;
  logic                    sticky_q, sticky_d;
  logic                    zero_q, zero_d;
  logic [RES_W-1:0]        res_q, res_d;
  logic                    ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;

  logic [CNT_W-1:0]        lzc_cnt_s;
  logic                    lzc_zero_s;
  logic                    guard_s, sticky_s, inc_s, carry_s, ovf_s, inf_sel_s;
  logic [MAN_W-1:0]        frac_s;
  logic signed [XW-1:0]    rexp_s;

  lzc #(.W(PROD_W), .CNT_W(CNT_W)) u_lzc (
    .in_vec   (prod_q),
    .cnt      (lzc_cnt_s),
    .all_zero (lzc_zero_s)
  );

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      prod_q   <= '0;
      exp_q    <= '0;
      sign_q   <= 1'b0;
      mode_q   <= RNE;
      sticky_q <= 1'b0;
      zero_q   <= 1'b0;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      inx_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prod_q   <= prod_d;
      exp_q    <= exp_d;
      sign_q   <= sign_d;
      mode_q   <= mode_d;
      sticky_q <= sticky_d;
      zero_q   <= zero_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      inx_q    <= inx_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = bus.in_valid ? ST_NORM : ST_IDLE;
      ST_NORM:  state_d = ST_ROUND;
      ST_ROUND: state_d = ST_HOLD;
      ST_HOLD:  state_d = bus.out_ready ? ST_IDLE : ST_HOLD;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the registered state.
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.out_valid = (state_q == ST_HOLD);
    bus.res       = res_q;
    bus.overflow  = ovf_q;
    bus.underflow = unf_q;
    bus.inexact   = inx_q;
  end

  // Rounding increment; carry only occurs when the stored fraction is all ones.
  always_comb begin
    guard_s  = prod_q[MAN_W-1];
    sticky_s = (|prod_q[MAN_W-2:0]) | sticky_q;
    case (mode_q)
      RNE:     inc_s = guard_s & (sticky_s | prod_q[MAN_W]);
      RTZ:     inc_s = 1'b0;
      RUP:     inc_s = ~sign_q & (guard_s | sticky_s);
      RDN:     inc_s = sign_q & (guard_s | sticky_s);
      default: inc_s = 1'b0;
    endcase
    frac_s    = prod_q[PROD_W-3 -: MAN_W] + MAN_W'(inc_s);
    carry_s   = inc_s & (&prod_q[PROD_W-3 -: MAN_W]);
    rexp_s    = exp_q + XW'(carry_s);
    ovf_s     = (rexp_s >= EXP_TOP);
    inf_sel_s = (mode_q == RNE) | ((mode_q == RUP) & ~sign_q) | ((mode_q == RDN) & sign_q);
  end

  // Datapath: latch on accept, normalise in NORM, pack and flag in ROUND.
  always_comb begin
    prod_d   = prod_q;
    exp_d    = exp_q;
    sign_d   = sign_q;
    mode_d   = mode_q;
    sticky_d = sticky_q;
    zero_d   = zero_q;
    res_d    = res_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    inx_d    = inx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.in_valid) begin
          prod_d   = bus.prod;
          exp_d    = bus.exp_in;
          sign_d   = bus.sign_in;
          mode_d   = bus.rnd_mode;
          sticky_d = 1'b0;
        end else begin
          sticky_d = sticky_q;
        end
      end
      ST_NORM: begin
        zero_d = lzc_zero_s;
        if (prod_q[PROD_W-1]) begin
          prod_d   = prod_q >> 1;
          exp_d    = exp_q + XW'(1);
          sticky_d = prod_q[0];
        end else if (prod_q[PROD_W-2]) begin
          prod_d = prod_q;
        end else begin
          prod_d = prod_q << (lzc_cnt_s - CNT_W'(1));
          exp_d  = exp_q - XW'(lzc_cnt_s) + XW'(1);
        end
      end
      ST_ROUND: begin
        ovf_d = 1'b0;
        unf_d = 1'b0;
        inx_d = 1'b0;
        if (zero_q) begin
          res_d = {sign_q, {(EXP_W + MAN_W){1'b0}}};
        end else if (ovf_s) begin
          ovf_d = 1'b1;
          inx_d = 1'b1;
          res_d = inf_sel_s ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                            : {sign_q, EXP_W'(exp_max_f(EXP_W) - 1), {MAN_W{1'b1}}};
        end else if (rexp_s <= XW'(0)) begin
          unf_d = 1'b1;
          inx_d = 1'b1;
          res_d = {sign_q, {(EXP_W + MAN_W){1'b0}}};
        end else begin
          inx_d = guard_s | sticky_s;
          res_d = {sign_q, rexp_s[EXP_W-1:0], frac_s};
        end
      end
      ST_HOLD: begin
        res_d = res_q;
      end
      default: begin
        res_d = res_q;
      end
    endcase
  end

endmodule

// File: tb/tb_fp_normalize_round.sv
// Directed bench for fp_normalize_round at MAN_W=23, EXP_W=8 with hand-computed results.
module tb_fp_normalize_round;
  import fpu_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fp_normalize_round_if #(.MAN_W(23), .EXP_W(8)) bus ();

  fp_normalize_round #(.MAN_W(23), .EXP_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  // One operation: accept, verify latency, then verify packed result and flags.
  task automatic run_op(input string tag, input logic [47:0] p, input logic signed [9:0] e,
                        input logic s, input rnd_mode_e m, input logic [31:0] eres,
                        input logic eo, input logic eu, input logic ei, input int hold);
    logic [34:0] got;
    @(negedge clk);
    chk({tag, "_rdy"}, 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1;
    bus.prod     = p;
    bus.exp_in   = e;
    bus.sign_in  = s;
    bus.rnd_mode = m;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    bus.prod = '0;
    @(negedge clk);
    chk({tag, "_c1"}, 64'({bus.out_valid, bus.in_ready}), 64'd0);
    @(negedge clk);
    chk({tag, "_c2"}, 64'({bus.out_valid, bus.in_ready}), 64'd0);
    @(negedge clk);
    chk({tag, "_c3"}, 64'({bus.out_valid, bus.in_ready}), 64'b10);
    got = {bus.res, bus.overflow, bus.underflow, bus.inexact};
    chk({tag, "_res"}, 64'(got), 64'({eres, eo, eu, ei}));
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold"}, 64'({bus.out_valid, bus.in_ready, bus.res, bus.overflow, bus.underflow, bus.inexact}),
          64'({2'b10, eres, eo, eu, ei}));
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.prod      = '0;
    bus.exp_in    = '0;
    bus.sign_in   = 1'b0;
    bus.rnd_mode  = RNE;
    bus.out_ready = 1'b0;
    #12;
    chk("reset", 64'({bus.in_ready, bus.out_valid, bus.res, bus.overflow, bus.underflow, bus.inexact}),
        64'({2'b10, 32'h0, 3'b000}));
    @(negedge clk);
    rst_n = 1'b1;

    run_op("rshift",   48'h9000_0000_0000, 10'sd127, 1'b0, RNE, 32'h4010_0000, 1'b0, 1'b0, 1'b0, 0);
    run_op("rne_up",   48'h4000_00C0_0000, 10'sd100, 1'b0, RNE, 32'h3200_0002, 1'b0, 1'b0, 1'b1, 0);
    run_op("rtz",      48'h4000_00C0_0000, 10'sd100, 1'b0, RTZ, 32'h3200_0001, 1'b0, 1'b0, 1'b1, 0);
    run_op("rne_tie",  48'h4000_0040_0000, 10'sd100, 1'b0, RNE, 32'h3200_0000, 1'b0, 1'b0, 1'b1, 0);
    run_op("carry",    48'h7FFF_FFC0_0000, 10'sd200, 1'b0, RNE, 32'h6480_0000, 1'b0, 1'b0, 1'b1, 0);
    run_op("lshift",   48'h1000_0000_0000, 10'sd130, 1'b0, RNE, 32'h4000_0000, 1'b0, 1'b0, 1'b0, 0);
    run_op("rup_pos",  48'h4000_0000_0001, 10'sd127, 1'b0, RUP, 32'h3F80_0001, 1'b0, 1'b0, 1'b1, 0);
    run_op("rdn_pos",  48'h4000_0000_0001, 10'sd127, 1'b0, RDN, 32'h3F80_0000, 1'b0, 1'b0, 1'b1, 0);
    run_op("rdn_neg",  48'h4000_0000_0001, 10'sd127, 1'b1, RDN, 32'hBF80_0001, 1'b0, 1'b0, 1'b1, 0);
    run_op("ovf_inf",  48'h8000_0000_0000, 10'sd254, 1'b1, RNE, 32'hFF80_0000, 1'b1, 1'b0, 1'b1, 0);
    run_op("ovf_max",  48'h8000_0000_0000, 10'sd254, 1'b1, RTZ, 32'hFF7F_FFFF, 1'b1, 1'b0, 1'b1, 0);
    run_op("ovf_rup",  48'h8000_0000_0000, 10'sd254, 1'b1, RUP, 32'hFF7F_FFFF, 1'b1, 1'b0, 1'b1, 0);
    run_op("unf",      48'h4000_0000_0000, 10'sd0,   1'b1, RNE, 32'h8000_0000, 1'b0, 1'b1, 1'b1, 0);
    run_op("zero",     48'h0000_0000_0000, 10'sd50,  1'b0, RNE, 32'h0000_0000, 1'b0, 1'b0, 1'b0, 0);
    run_op("bp",       48'h9000_0000_0000, 10'sd127, 1'b0, RNE, 32'h4010_0000, 1'b0, 1'b0, 1'b0, 5);

    // Abort an operation while it sits in ROUND.
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.prod     = 48'h4000_00C0_0000;
    bus.exp_in   = 10'sd100;
    bus.sign_in  = 1'b0;
    bus.rnd_mode = RNE;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst_async", 64'({bus.in_ready, bus.out_valid, bus.res}), 64'({2'b10, 32'h0}));
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_after", 64'({bus.in_ready, bus.out_valid}), 64'b10);
    end
    run_op("recover",  48'h4000_00C0_0000, 10'sd100, 1'b0, RTZ, 32'h3200_0001, 1'b0, 1'b0, 1'b1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
